sme_drv: RTL and testbench
==========================

SME_DRV -- requirements
Module: sme_drv

Interface
REQ-001 Parameter MAX_LEN, default 32, maximum characters per record (string or pattern).
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, watchdog limit in WAIT state (used only under REQ-030).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  host byte valid.
REQ-006 in_ready  output  1  block accepts byte this cycle.
REQ-007 in_data  input  8  host character.
REQ-008 in_type  input  1  record type: 0 = string, 1 = pattern; sampled on first byte of record.
REQ-009 in_last  input  1  final byte of record.
REQ-010 chardata  output  8  character to string-match engine.
REQ-011 isstring  output  1  chardata is a string character.
REQ-012 ispattern  output  1  chardata is a pattern character.
REQ-013 sme_valid  input  1  engine result strobe.
REQ-014 sme_match  input  1  engine match flag.
REQ-015 sme_match_index  input  5  engine match position.
REQ-016 res_valid  output  1  result available to host.
REQ-017 res_ready  input  1  host takes result.
REQ-018 res_match  output  1  captured match flag.
REQ-019 res_index  output  5  captured match index.
REQ-020 res_timeout  output  1  result produced by watchdog, not engine.

Function
REQ-021 FSM states IDLE, LOAD, SEND, WAIT, REPORT; IDLE is the reset state.
REQ-022 in_ready SHALL be 1 only in IDLE and LOAD; a byte transfers when in_valid && in_ready.
REQ-023 IDLE: first transferred byte is written to buffer entry 0, in_type latched, count=1; go LOAD, or SEND if in_last.
REQ-024 LOAD: each transfer writes entry count, count+1; transfer with in_last or with count+1==MAX_LEN (forced last) moves to SEND; in_type of non-first bytes ignored.
REQ-025 SEND: drive entry k on chardata in the k-th SEND cycle for count cycles, first char in the cycle after the last byte transfers; isstring (type 0) or ispattern (type 1) held 1 for exactly those cycles, both 0 otherwise.
REQ-026 After last SEND cycle: type 0 returns to IDLE, type 1 enters WAIT; chardata holds last value when flags are 0.
REQ-027 WAIT: on sme_valid capture sme_match/sme_match_index into res_match/res_index, res_timeout=0, go REPORT; sme_valid in any other state is ignored.
REQ-028 REPORT: res_valid=1 until cycle with res_ready=1, then IDLE; res_* stable while res_valid=1.
REQ-029 All outputs registered; no combinational path from any input to any output except in_ready, which depends on state only.

Configuration
REQ-030 Macro SME_DRV_TIMEOUT_EN: when defined, WAIT counts cycles and after TIMEOUT_CYCLES cycles without sme_valid enters REPORT with res_match=0, res_index=0, res_timeout=1; sme_valid on the same cycle as expiry wins (res_timeout=0). Without the macro, no counter exists, WAIT is unbounded, and res_timeout is tied 0.

Reset
REQ-031 reset low SHALL immediately force IDLE, count=0, in_ready=0 while reset is asserted, chardata=0, isstring=0, ispattern=0, res_valid=0, res_match=0, res_index=0, res_timeout=0, timeout counter 0.
REQ-032 Reset mid-record or mid-SEND discards the partial record; no flag pulse is emitted after release.
REQ-033 Buffer contents need not be reset.

Verification
REQ-034 String "abc" (type 0, last on 'c') -> isstring=1 for 3 consecutive cycles carrying 0x61,0x62,0x63, starting the cycle after 'c' transfers; no result; back to IDLE.
REQ-035 Pattern "b" after REQ-034, engine returns sme_valid with match=1,index=1 after 4 cycles -> ispattern=1 for 1 cycle with 0x62; res_valid=1, res_match=1, res_index=1, res_timeout=0, held 3 cycles with res_ready=0, cleared after res_ready.
REQ-036 33-byte string without in_last -> forced last at byte 32, in_ready=0 during SEND, byte 33 transferred as first byte of next record.
REQ-037 Pattern sent, engine silent, SME_DRV_TIMEOUT_EN defined, TIMEOUT_CYCLES=16 -> res_valid after 16 WAIT cycles with res_timeout=1, res_match=0; undefined -> stays in WAIT indefinitely, res_valid=0.
REQ-038 reset asserted in SEND cycle 2 of a 5-char string -> isstring=0 asynchronously, in_ready=1 one cycle after release, no further chardata pulses.

Source files
------------

// File: rtl/sme_drv.sv
// rtl/sme_drv.sv - host-to-string-match-engine record driver with result capture
// Optional watchdog in WAIT enabled by defining SME_DRV_TIMEOUT_EN.
module sme_drv #(
  parameter int MAX_LEN        = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_type,
  input  logic       in_last,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_match_index,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_timeout
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int CW = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT, S_REPORT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   send_idx_q, send_idx_d;
  logic            type_q, type_d;
  logic            in_ready_q, in_ready_d;
  logic [7:0]      chardata_q, chardata_d;
  logic            isstring_q, isstring_d;
  logic            ispattern_q, ispattern_d;
  logic            res_valid_q, res_valid_d;
  logic            res_match_q, res_match_d;
  logic [4:0]      res_index_q, res_index_d;
  logic [7:0]      buf_q [MAX_LEN];
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic            xfer;

`ifdef SME_DRV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            res_timeout_q, res_timeout_d;
`endif

  assign xfer = in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    send_idx_d  = send_idx_q;
    type_d      = type_q;
    chardata_d  = chardata_q;
    isstring_d  = 1'b0;
    ispattern_d = 1'b0;
    res_valid_d = res_valid_q;
    res_match_d = res_match_q;
    res_index_d = res_index_q;
    wr_en       = 1'b0;
    wr_addr     = '0;
`ifdef SME_DRV_TIMEOUT_EN
    tmo_d         = tmo_q;
    res_timeout_d = res_timeout_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          wr_en   = 1'b1;
          type_d  = in_type;
          count_d = CW'(1);
          if (in_last) begin
            // Entry 0 is still being written, so the first char comes from the bus.
            state_d     = S_SEND;
            chardata_d  = in_data;
            isstring_d  = ~in_type;
            ispattern_d = in_type;
            send_idx_d  = CW'(1);
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (xfer) begin
          wr_en   = 1'b1;
          wr_addr = count_q[AW-1:0];
          count_d = count_q + CW'(1);
          if (in_last || (count_q + CW'(1)) == CW'(MAX_LEN)) begin
            state_d     = S_SEND;
            chardata_d  = buf_q[0];
            isstring_d  = ~type_q;
            ispattern_d = type_q;
            send_idx_d  = CW'(1);
          end
        end
      end
      S_SEND: begin
        if (send_idx_q < count_q) begin
          chardata_d  = buf_q[send_idx_q[AW-1:0]];
          isstring_d  = ~type_q;
          ispattern_d = type_q;
          send_idx_d  = send_idx_q + CW'(1);
        end else begin
          count_d = '0;
          state_d = type_q ? S_WAIT : S_IDLE;
        end
      end
      S_WAIT: begin
        if (sme_valid) begin
          res_valid_d = 1'b1;
          res_match_d = sme_match;
          res_index_d = sme_match_index;
          state_d     = S_REPORT;
`ifdef SME_DRV_TIMEOUT_EN
          res_timeout_d = 1'b0;
          tmo_d         = '0;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          res_valid_d   = 1'b1;
          res_match_d   = 1'b0;
          res_index_d   = '0;
          res_timeout_d = 1'b1;
          tmo_d         = '0;
          state_d       = S_REPORT;
        end else begin
          tmo_d = tmo_q + TW'(1);
`endif
        end
      end
      S_REPORT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      send_idx_q  <= '0;
      type_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      chardata_q  <= '0;
      isstring_q  <= 1'b0;
      ispattern_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_match_q <= 1'b0;
      res_index_q <= '0;
`ifdef SME_DRV_TIMEOUT_EN
      tmo_q         <= '0;
      res_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      send_idx_q  <= send_idx_d;
      type_q      <= type_d;
      in_ready_q  <= in_ready_d;
      chardata_q  <= chardata_d;
      isstring_q  <= isstring_d;
      ispattern_q <= ispattern_d;
      res_valid_q <= res_valid_d;
      res_match_q <= res_match_d;
      res_index_q <= res_index_d;
`ifdef SME_DRV_TIMEOUT_EN
      tmo_q         <= tmo_d;
      res_timeout_q <= res_timeout_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) buf_q[wr_addr] <= in_data;
  end

  assign in_ready  = in_ready_q;
  assign chardata  = chardata_q;
  assign isstring  = isstring_q;
  assign ispattern = ispattern_q;
  assign res_valid = res_valid_q;
  assign res_match = res_match_q;
  assign res_index = res_index_q;
`ifdef SME_DRV_TIMEOUT_EN
  assign res_timeout = res_timeout_q;
`else
  assign res_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sme_drv.sv
// tb/tb_sme_drv.sv - directed and randomized record traffic against a queue-based expectation
module tb_sme_drv;
  localparam int MAX_LEN = 32;
  localparam int TO      = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0, in_type = 1'b0, in_last = 1'b0;
  logic [7:0] in_data = '0;
  logic       sme_valid = 1'b0, sme_match = 1'b0, res_ready = 1'b0;
  logic [4:0] sme_match_index = '0;
  logic       in_ready, isstring, ispattern, res_valid, res_match, res_timeout;
  logic [7:0] chardata;
  logic [4:0] res_index;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] rec_q[$];

  always #5 clk = ~clk;

  sme_drv #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_type(in_type), .in_last(in_last),
    .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
    .sme_valid(sme_valid), .sme_match(sme_match), .sme_match_index(sme_match_index),
    .res_valid(res_valid), .res_ready(res_ready), .res_match(res_match),
    .res_index(res_index), .res_timeout(res_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Offers rec_q[0..n-1] as one record; returns at the first SEND-cycle sample point.
  task automatic push_bytes(input int n, input bit typ, input bit mark_last, input int gap_max);
    int w;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap_max)) begin in_valid = 1'b0; step(); end
      in_valid = 1'b1;
      in_data  = rec_q[i];
      in_type  = (i == 0) ? typ : 1'($urandom);
      in_last  = mark_last && (i == n - 1);
      w = 0;
      while (in_ready !== 1'b1 && w < 100) begin step(); w++; end
      check("in_ready_load", in_ready, 1);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_send(input int n, input bit typ);
    for (int k = 0; k < n; k++) begin
      check("isstring_send", isstring, !typ);
      check("ispattern_send", ispattern, typ);
      check("chardata_send", chardata, rec_q[k]);
      check("in_ready_send", in_ready, 0);
      step();
    end
    check("isstring_after", isstring, 0);
    check("ispattern_after", ispattern, 0);
    check("chardata_hold", chardata, rec_q[n-1]);
    check("in_ready_after", in_ready, !typ);
  endtask

  task automatic engine_reply(input int delay, input bit m, input logic [4:0] idx);
    repeat (delay) begin check("res_valid_wait", res_valid, 0); step(); end
    sme_valid = 1'b1; sme_match = m; sme_match_index = idx;
    step();
    sme_valid = 1'b0; sme_match = 1'($urandom); sme_match_index = 5'($urandom);
    for (int c = 0; c < 3; c++) begin
      check("res_valid_hold", res_valid, 1);
      check("res_match", res_match, m);
      check("res_index", res_index, idx);
      check("res_timeout", res_timeout, 0);
      step();
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("res_valid_clear", res_valid, 0);
    check("in_ready_idle", in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    bit typ, m;
    logic [4:0] idx;
    logic [7:0] b33, b34;

    #1 reset = 1'b0;
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_isstring", isstring, 0);
    check("rst_ispattern", ispattern, 0);
    check("rst_chardata", chardata, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_match", res_match, 0);
    check("rst_res_index", res_index, 0);
    check("rst_res_timeout", res_timeout, 0);
    step(); step();
    reset = 1'b1;
    check("rel_in_ready_low", in_ready, 0);
    step();
    check("rel_in_ready_high", in_ready, 1);

    rec_q = '{8'h61, 8'h62, 8'h63};
    push_bytes(3, 1'b0, 1'b1, 0);
    check_send(3, 1'b0);
    repeat (3) begin check("abc_no_result", res_valid, 0); step(); end

    sme_valid = 1'b1; sme_match = 1'b1; sme_match_index = 5'd7;
    step();
    sme_valid = 1'b0;
    check("idle_sme_ignored_valid", res_valid, 0);
    check("idle_sme_ignored_match", res_match, 0);

    rec_q = '{8'h62};
    push_bytes(1, 1'b1, 1'b1, 0);
    check_send(1, 1'b1);
    engine_reply(4, 1'b1, 5'd1);

    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, MAX_LEN);
      typ = 1'($urandom);
      rec_q = {};
      for (int i = 0; i < len; i++) rec_q.push_back(8'($urandom));
      push_bytes(len, typ, 1'b1, 2);
      check_send(len, typ);
      if (typ) begin
        m   = 1'($urandom);
        idx = 5'($urandom);
        engine_reply($urandom_range(0, 6), m, idx);
      end
    end

    rec_q = {};
    for (int i = 0; i < MAX_LEN; i++) rec_q.push_back(8'($urandom));
    b33 = 8'($urandom);
    b34 = 8'($urandom);
    push_bytes(MAX_LEN, 1'b0, 1'b0, 0);
    in_valid = 1'b1; in_data = b33; in_type = 1'b0; in_last = 1'b0;
    check_send(MAX_LEN, 1'b0);
    rec_q = '{b33, b34};
    push_bytes(2, 1'b0, 1'b1, 0);
    check_send(2, 1'b0);

    rec_q = {};
    for (int i = 0; i < 5; i++) rec_q.push_back(8'($urandom) | 8'h01);
    push_bytes(5, 1'b0, 1'b1, 0);
    check("rst_mid_send_c1", chardata, rec_q[0]);
    step();
    check("rst_mid_send_c2_flag", isstring, 1);
    #1 reset = 1'b0;
    #1;
    check("rst_async_isstring", isstring, 0);
    check("rst_async_chardata", chardata, 0);
    check("rst_async_in_ready", in_ready, 0);
    step(); step();
    reset = 1'b1;
    check("rst2_in_ready_low", in_ready, 0);
    step();
    check("rst2_in_ready_high", in_ready, 1);
    repeat (8) begin
      check("post_rst_isstring", isstring, 0);
      check("post_rst_ispattern", ispattern, 0);
      step();
    end

    rec_q = '{8'h11, 8'h22, 8'h33};
    push_bytes(3, 1'b1, 1'b1, 1);
    check_send(3, 1'b1);
`ifdef SME_DRV_TIMEOUT_EN
    check("tmo_wait_c1", res_valid, 0);
    repeat (TO - 1) begin step(); check("tmo_wait", res_valid, 0); end
    step();
    check("tmo_res_valid", res_valid, 1);
    check("tmo_res_timeout", res_timeout, 1);
    check("tmo_res_match", res_match, 0);
    check("tmo_res_index", res_index, 0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("tmo_res_clear", res_valid, 0);
    check("tmo_in_ready", in_ready, 1);
`else
    repeat (200) begin
      check("wait_forever_valid", res_valid, 0);
      check("wait_forever_timeout", res_timeout, 0);
      step();
    end
    check("wait_in_ready", in_ready, 0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    check("wait_recover_in_ready", in_ready, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
